dual_fetch_unit: RTL and testbench
==================================

// Module: dual_fetch_unit
// PURPOSE
//  Fetch initiator for the dual-issue instruction memory. Drives an 8-byte-aligned
//  fetch address, captures the returned instruction pair (instr1/instr2) into a
//  small pair FIFO, and presents one pair per cycle to decode with ready/valid.
//  Handles branch/jump redirect with buffer flush and misaligned (pc[2]=1) targets.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC after reset (low 3 bits must be 0)
//  DEPTH       2              pair FIFO entries (power of 2, >=2)
//  IMEM_WORDS  64             memory size in 32-bit words; fetch PC wraps at IMEM_WORDS*4
//  LANE2_EN    0              1: lane 2 valid per alignment; 0: lane 2 always invalid (nop)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-high reset
//  imem_addr     out  32  fetch byte address, always {fetch_pc[31:3],3'b000}
//  imem_instr1   in   32  word at imem_addr (combinational from memory)
//  imem_instr2   in   32  word at imem_addr+4
//  redirect      in   1   taken branch/jump: flush and restart fetch
//  redirect_pc   in   32  new PC; bits [1:0] ignored (treated as 0)
//  dec_valid     out  1   head pair available
//  dec_ready     in   1   decode accepts head pair this cycle
//  dec_pc        out  32  aligned byte address of head pair
//  dec_instr1    out  32  head lane-1 word (32'h0 when dec_valid1=0)
//  dec_instr2    out  32  head lane-2 word (32'h0 when dec_valid2=0)
//  dec_valid1    out  1   lane 1 holds a real instruction
//  dec_valid2    out  1   lane 2 holds a real instruction
//  fifo_count    out  $clog2(DEPTH)+1  occupancy (debug)
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, FIFO empty, skip1=0; dec_* outputs all 0, fifo_count=0.
//  - Push: every cycle with !redirect and (count<DEPTH or pop) -> store {aligned pc,
//    instr1, instr2, v1=!skip1, v2=LANE2_EN}; skip1 <= 0; fetch_pc advances by 8.
//  - Pop: dec_valid && dec_ready removes head. Push+pop when full allowed; count unchanged.
//  - Full and no pop: no push, fetch_pc held, imem_addr stable.
//  - Head outputs come straight from FIFO head register (no comb path from imem to dec_*).
//  - Fetch latency: pair at address A pushed at end of cycle where imem_addr=A;
//    visible on dec_* the following cycle.
//  - Redirect (highest priority): FIFO flushed (count=0, pointers reset), any same-cycle
//    pop and push discarded; fetch_pc <= {redirect_pc[31:3],3'b000};
//    skip1 <= redirect_pc[2]. dec_valid=0 the next cycle; first new pair has dec_valid=1
//    two cycles after the redirect cycle.
//  - pc[2]=1 target: first pair has dec_valid1=0, dec_instr1=0; dec_valid2 per LANE2_EN.
//    With LANE2_EN=0 that pair is an empty bubble but is still delivered (decode drops it).
//  - Wrap: next fetch_pc = (aligned+8) mod (IMEM_WORDS*4); 32-bit arithmetic, no overflow flag.
//  - Redirect while empty or while full: same flush behaviour, no special case.
//  - Reset mid-operation: all state cleared immediately, in-flight pairs lost.
// STRUCTURE
//  - Shared include mips_fetch_defs.vh: NOP_INSTR=32'h0000_0000, PAIR_BYTES=8,
//    pair-entry field widths/offsets (pc, instr1, instr2, v1, v2 = 98 bits).
//  - Sub-module pair_fifo: DEPTH x WIDTH register FIFO with push/pop/flush, count,
//    registered head; dual_fetch_unit holds the PC, skip1, redirect and push/pop logic.
// TESTING (bench connects Instruction_Memory_Dual-style Fibonacci image, LANE2_EN=0)
//  1 reset released, dec_ready=1 -> imem_addr 0,8,16..; first dec_pc=0,
//    dec_instr1=32'h8C01_0000, dec_valid1=1, dec_valid2=0, dec_instr2=0.
//  2 dec_ready=0 for 5 cycles -> fifo_count saturates at 2, imem_addr frozen, head
//    pair unchanged; dec_ready=1 -> pairs resume in order, none lost or duplicated.
//  3 redirect=1, redirect_pc=32'h18 -> next cycle dec_valid=0; two cycles after,
//    dec_pc=32'h18, dec_instr1=32'h0022_1820 (add $3,$1,$2).
//  4 redirect_pc=32'h1C -> first pair dec_pc=32'h18, dec_valid1=0, dec_instr1=0;
//    next pair dec_pc=32'h20, dec_instr1=32'h0040_0820.
//  5 run with dec_ready=1 from 32'hF8 -> next dec_pc wraps to 32'h0 (IMEM_WORDS=64).
//  6 assert reset while fifo_count=2 and redirect pending -> all dec_* 0 immediately,
//    fetch restarts at RESET_PC after release; repeat with LANE2_EN=1: dec_valid2=1.

Source files
------------

// File: rtl/dual_fetch_unit_pkg.sv
// Shared definitions for the dual-issue fetch unit: pair-entry layout and helpers.
package dual_fetch_unit_pkg;

  localparam logic [31:0]  NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned  PAIR_BYTES = 8;

  // One fetched instruction pair as held in the pair FIFO (98 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic        v1;
    logic        v2;
  } pair_entry_t;

  localparam int unsigned ENTRY_W = $bits(pair_entry_t);

  // Clear the low three bits so the address names a whole pair.
  function automatic logic [31:0] align_pair(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/dual_fetch_unit_pair_fifo.sv
// pair_fifo: DEPTH x WIDTH register FIFO with push/pop/flush and a head read
// straight from the storage registers.
//   clk, reset  clock, async active-high reset
//   push, din   write din at tail (caller guarantees space or simultaneous pop)
//   pop         drop head entry (caller guarantees non-empty)
//   flush       empty the FIFO; overrides push/pop
//   head        current head entry
//   count       occupancy 0..DEPTH
module pair_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 98
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit: fetch initiator for the dual-issue instruction memory.
// Holds the fetch PC, pushes one instruction pair per cycle into a pair FIFO and
// presents the head pair to decode with ready/valid; handles redirect + flush.
//   clk, reset            clock, async active-high reset
//   imem_addr             8-byte aligned fetch address
//   imem_instr1/2         words at imem_addr and imem_addr+4
//   redirect, redirect_pc taken branch/jump and its target
//   dec_valid/dec_ready   handshake for the head pair
//   dec_pc, dec_instr1/2  head pair; lanes zeroed when their valid is low
//   dec_valid1/2          per-lane real-instruction flags
//   fifo_count            pair FIFO occupancy
module dual_fetch_unit
  import dual_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IMEM_WORDS = 64,
  parameter bit          LANE2_EN   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_instr1,
  input  logic [31:0]              imem_instr2,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_pc,
  output logic [31:0]              dec_instr1,
  output logic [31:0]              dec_instr2,
  output logic                     dec_valid1,
  output logic                     dec_valid2,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  logic [31:0]  fetch_pc;
  logic         skip1;
  logic         push;
  logic         pop;
  logic [CW-1:0] count;
  pair_entry_t  din;
  pair_entry_t  head;
  logic         unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign imem_addr = align_pair(fetch_pc);
  assign dec_valid = (count != '0);

  // Redirect discards any same-cycle pop and push.
  assign pop  = dec_valid && dec_ready && !redirect;
  assign push = !redirect && ((count < CW'(DEPTH)) || pop);

  // Lanes are zeroed on the way in so the head needs no masking per lane.
  always_comb begin
    din        = '0;
    din.pc     = imem_addr;
    din.v1     = !skip1;
    din.v2     = LANE2_EN;
    din.instr1 = skip1    ? NOP_INSTR   : imem_instr1;
    din.instr2 = LANE2_EN ? imem_instr2 : NOP_INSTR;
  end

  pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .count (count)
  );

  // Fetch PC and first-lane skip for misaligned redirect targets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      skip1    <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= align_pair(redirect_pc);
      skip1    <= redirect_pc[2];
    end else if (push) begin
      fetch_pc <= (imem_addr + 32'(PAIR_BYTES)) % PC_LIMIT;
      skip1    <= 1'b0;
    end
  end

  // Stale storage behind an empty FIFO is hidden from decode.
  assign dec_pc     = dec_valid ? head.pc     : 32'h0;
  assign dec_instr1 = dec_valid ? head.instr1 : 32'h0;
  assign dec_instr2 = dec_valid ? head.instr2 : 32'h0;
  assign dec_valid1 = dec_valid && head.v1;
  assign dec_valid2 = dec_valid && head.v2;
  assign fifo_count = count;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Bench for dual_fetch_unit: two instances (LANE2_EN=0 and 1) share stimulus and a
// Fibonacci-style instruction image; a reference queue model predicts the head pair.
module tb_dual_fetch_unit;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        skip;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_ready = 1'b0;

  logic [31:0] addr_a, i1_a, i2_a, pc_a, d1_a, d2_a;
  logic [31:0] addr_b, i1_b, i2_b, pc_b, d1_b, d2_b;
  logic        val_a, v1_a, v2_a, val_b, v1_b, v2_b;
  logic [1:0]  cnt_a, cnt_b;
  logic [98:0] got_a, got_b;

  logic [31:0] image [64];
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_skip;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  assign i1_a = image[addr_a[7:2]];
  assign i2_a = image[6'(addr_a[7:2] + 6'd1)];
  assign i1_b = image[addr_b[7:2]];
  assign i2_b = image[6'(addr_b[7:2] + 6'd1)];
  assign got_a = {val_a, pc_a, d1_a, d2_a, v1_a, v2_a};
  assign got_b = {val_b, pc_b, d1_b, d2_b, v1_b, v2_b};

  dual_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .IMEM_WORDS(64), .LANE2_EN(1'b0)) dut_a (
    .clk(clk), .reset(reset), .imem_addr(addr_a), .imem_instr1(i1_a), .imem_instr2(i2_a),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_valid(val_a), .dec_ready(dec_ready),
    .dec_pc(pc_a), .dec_instr1(d1_a), .dec_instr2(d2_a), .dec_valid1(v1_a), .dec_valid2(v2_a),
    .fifo_count(cnt_a));

  dual_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .IMEM_WORDS(64), .LANE2_EN(1'b1)) dut_b (
    .clk(clk), .reset(reset), .imem_addr(addr_b), .imem_instr1(i1_b), .imem_instr2(i2_b),
    .redirect(redirect), .redirect_pc(redirect_pc), .dec_valid(val_b), .dec_ready(dec_ready),
    .dec_pc(pc_b), .dec_instr1(d1_b), .dec_instr2(d2_b), .dec_valid1(v1_b), .dec_valid2(v2_b),
    .fifo_count(cnt_b));

  // Expected head for a given lane-2 setting, from the model queue.
  function automatic logic [98:0] exp_vec(input bit lane2);
    if (q.size() == 0) return '0;
    return {1'b1, q[0].pc, (q[0].skip ? 32'h0 : q[0].i1), (lane2 ? q[0].i2 : 32'h0),
            1'(!q[0].skip), 1'(lane2)};
  endfunction

  // One clock: model reacts to the inputs held across the edge, then settle past it.
  task automatic step();
    bit   pop, push;
    ent_t e;
    pop    = (q.size() != 0) && dec_ready && !redirect;
    push   = !redirect && ((q.size() < DEPTH) || pop);
    e.pc   = m_pc;
    e.i1   = image[m_pc[7:2]];
    e.i2   = image[6'(m_pc[7:2] + 6'd1)];
    e.skip = m_skip;
    @(posedge clk);
    if (reset) begin
      q.delete(); m_pc = 32'h0; m_skip = 1'b0;
    end else if (redirect) begin
      q.delete(); m_pc = {redirect_pc[31:3], 3'b000}; m_skip = redirect_pc[2];
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        m_skip = 1'b0;
        m_pc   = (m_pc + 32'd8) % 32'd256;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (got_a !== '0 || got_b !== '0 || cnt_a !== 2'd0 || addr_a !== 32'h0 || addr_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got %h cnt %0d addr %h, want all 0", got_a, cnt_a, addr_a);
    end
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    dec_ready = 1'b1;
    step();
    vectors++;
    if (pc_a !== 32'h0 || d1_a !== 32'h8C01_0000 || v1_a !== 1'b1 || v2_a !== 1'b0 ||
        d2_a !== 32'h0 || val_a !== 1'b1 || addr_a !== 32'h8) begin
      errors++;
      $display("FAIL first_pair: got pc %h i1 %h v %b%b%b i2 %h addr %h, want 0 8c010000 111->v2 0 0 8",
               pc_a, d1_a, val_a, v1_a, v2_a, d2_a, addr_a);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (got_a !== exp_vec(1'b0) || got_b !== exp_vec(1'b1) || addr_a !== m_pc ||
          addr_b !== m_pc || cnt_a !== 2'(q.size())) begin
        errors++;
        $display("FAIL fetch_sb: got %h/%h addr %h cnt %0d want %h/%h addr %h cnt %0d",
                 got_a, got_b, addr_a, cnt_a, exp_vec(1'b0), exp_vec(1'b1), m_pc, q.size());
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] head_pc, frozen;
    head_pc = q[0].pc;
    frozen  = m_pc + 32'd8;
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (cnt_a !== 2'd2 || addr_a !== frozen || pc_a !== head_pc || got_a !== exp_vec(1'b0)) begin
      errors++;
      $display("FAIL stall_hold: got cnt %0d addr %h pc %h want cnt 2 addr %h pc %h",
               cnt_a, addr_a, pc_a, frozen, head_pc);
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (got_a !== exp_vec(1'b0) || got_b !== exp_vec(1'b1) || addr_a !== m_pc ||
          cnt_a !== 2'(q.size()) || pc_a !== head_pc + 32'(8 * (i + 1))) begin
        errors++;
        $display("FAIL resume_sb: got %h addr %h cnt %0d want %h addr %h cnt %0d pc %h",
                 got_a, addr_a, cnt_a, exp_vec(1'b0), m_pc, q.size(), head_pc + 32'(8 * (i + 1)));
      end
    end
  endtask

  task automatic test_redirect_aligned();
    redirect = 1'b1; redirect_pc = 32'h18;
    step();
    redirect = 1'b0;
    vectors++;
    if (val_a !== 1'b0 || val_b !== 1'b0 || cnt_a !== 2'd0 || addr_a !== 32'h18) begin
      errors++;
      $display("FAIL redir_bubble: got valid %b cnt %0d addr %h want 0 0 18", val_a, cnt_a, addr_a);
    end
    step();
    vectors++;
    if (val_a !== 1'b1 || pc_a !== 32'h18 || d1_a !== 32'h0022_1820 || v1_a !== 1'b1 ||
        got_a !== exp_vec(1'b0) || got_b !== exp_vec(1'b1)) begin
      errors++;
      $display("FAIL redir_target: got pc %h i1 %h v %b want 18 00221820 1", pc_a, d1_a, val_a);
    end
  endtask

  task automatic test_redirect_misaligned();
    redirect = 1'b1; redirect_pc = 32'h1C;
    step();
    redirect = 1'b0;
    vectors++;
    if (val_a !== 1'b0) begin
      errors++;
      $display("FAIL mis_bubble: got valid %b want 0", val_a);
    end
    step();
    vectors++;
    if (val_a !== 1'b1 || pc_a !== 32'h18 || v1_a !== 1'b0 || d1_a !== 32'h0 || v2_a !== 1'b0 ||
        v2_b !== 1'b1 || d2_b !== 32'h0001_1020 || v1_b !== 1'b0) begin
      errors++;
      $display("FAIL mis_first: got pc %h v1 %b i1 %h v2a %b v2b %b i2b %h want 18 0 0 0 1 00011020",
               pc_a, v1_a, d1_a, v2_a, v2_b, d2_b);
    end
    step();
    vectors++;
    if (pc_a !== 32'h20 || d1_a !== 32'h0040_0820 || v1_a !== 1'b1 || got_b !== exp_vec(1'b1)) begin
      errors++;
      $display("FAIL mis_second: got pc %h i1 %h v1 %b want 20 00400820 1", pc_a, d1_a, v1_a);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hF0; want[1] = 32'hF8; want[2] = 32'h0;
    redirect = 1'b1; redirect_pc = 32'hF0;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pc_a !== want[i] || val_a !== 1'b1 || got_a !== exp_vec(1'b0) || got_b !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL wrap_pc: got pc %h valid %b want %h", pc_a, val_a, want[i]);
      end
    end
    vectors++;
    if (addr_a !== 32'h8) begin
      errors++;
      $display("FAIL wrap_addr: got %h want 00000008", addr_a);
    end
  endtask

  task automatic test_redirect_full_empty();
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if (cnt_a !== 2'd2) begin
      errors++;
      $display("FAIL fill_count: got %0d want 2", cnt_a);
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h44;
    step();
    redirect = 1'b0;
    vectors++;
    if (cnt_a !== 2'd0 || val_a !== 1'b0 || addr_a !== 32'h40) begin
      errors++;
      $display("FAIL flush_full: got cnt %0d valid %b addr %h want 0 0 40", cnt_a, val_a, addr_a);
    end
    step();
    vectors++;
    if (pc_a !== 32'h40 || v1_a !== 1'b0 || val_a !== 1'b1 || got_b !== exp_vec(1'b1)) begin
      errors++;
      $display("FAIL redir_empty: got pc %h v1 %b valid %b want 40 0 1", pc_a, v1_a, val_a);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step();
    redirect = 1'b1; redirect_pc = 32'h30;
    reset = 1'b1;
    #1;
    q.delete(); m_pc = 32'h0; m_skip = 1'b0;
    vectors++;
    if (got_a !== '0 || got_b !== '0 || cnt_a !== 2'd0 || cnt_b !== 2'd0 || addr_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%h cnt %0d addr %h want all 0", got_a, got_b, cnt_a, addr_a);
    end
    step();
    reset = 1'b0; redirect = 1'b0; dec_ready = 1'b1;
    step();
    vectors++;
    if (pc_a !== 32'h0 || d1_a !== 32'h8C01_0000 || v2_b !== 1'b1 || d2_b !== 32'h8C02_0004 ||
        v2_a !== 1'b0 || d2_a !== 32'h0) begin
      errors++;
      $display("FAIL restart: got pc %h i1 %h v2b %b i2b %h v2a %b want 0 8c010000 1 8c020004 0",
               pc_a, d1_a, v2_b, d2_b, v2_a);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (got_a !== exp_vec(1'b0) || got_b !== exp_vec(1'b1) || addr_b !== m_pc) begin
        errors++;
        $display("FAIL restart_sb: got %h/%h want %h/%h", got_a, got_b, exp_vec(1'b0), exp_vec(1'b1));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) image[i] = 32'h2000_0000 | 32'(i);
    image[0] = 32'h8C01_0000;
    image[1] = 32'h8C02_0004;
    image[6] = 32'h0022_1820;
    image[7] = 32'h0001_1020;
    image[8] = 32'h0040_0820;
    m_pc   = 32'h0;
    m_skip = 1'b0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_aligned();
    test_redirect_misaligned();
    test_wrap();
    test_redirect_full_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
